// File: rtl/wb_trace_buffer_if.sv
// Writeback sample inputs and FWFT read-side handshake for the writeback trace buffer.
interface wb_trace_buffer_if #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int TS_W   = 16
);
  logic [NCH-1:0]        wb_wr;
  logic [NCH*ADDR_W-1:0] wb_addr;
  logic [NCH*DATA_W-1:0] wb_data;
  logic                  rd_ready;
  logic                  rd_valid;
  logic [TS_W-1:0]       rd_ts;
  logic [NCH-1:0]        rd_mask;
  logic [NCH*ADDR_W-1:0] rd_addr;
  logic [NCH*DATA_W-1:0] rd_data;

  modport master (
    output wb_wr, wb_addr, wb_data, rd_ready,
    input  rd_valid, rd_ts, rd_mask, rd_addr, rd_data
  );

  modport slave (
    input  wb_wr, wb_addr, wb_data, rd_ready,
    output rd_valid, rd_ts, rd_mask, rd_addr, rd_data
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Writeback trace capture: samples NCH writeback ports inside a bounded window into a
// FWFT FIFO of {timestamp, mask, addr, data}, with sticky overflow and saturating drop count.
module wb_trace_buffer #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TS_W-1:0]   cycle_limit,
  wb_trace_buffer_if.slave  bus,
  output logic [CNT_W-1:0]  count,
  output logic              capturing,
  output logic              done,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam int EW = TS_W + NCH + NCH*ADDR_W + NCH*DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [TS_W-1:0]   limit_q, limit_d;
  logic [7:0]        drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [EW-1:0]     wr_entry_d;
  logic [EW-1:0]     head;

  logic [NCH*ADDR_W-1:0] masked_addr;
  logic [NCH*DATA_W-1:0] masked_data;
  logic push_req, push_ok, pop, full, empty;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign pop      = !empty && bus.rd_ready;
  // The start cycle belongs to neither the old nor the new window, so it never pushes.
  assign push_req = (state_q == S_CAPTURE) && (|bus.wb_wr) && !start;
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    masked_addr = '0;
    masked_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.wb_wr[i]) begin
        masked_addr[i*ADDR_W +: ADDR_W] = bus.wb_addr[i*ADDR_W +: ADDR_W];
        masked_data[i*DATA_W +: DATA_W] = bus.wb_data[i*DATA_W +: DATA_W];
      end
    end
    wr_entry_d = {ts_q, bus.wb_wr, masked_addr, masked_data};
  end

  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    limit_d = limit_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    if (push_req && !push_ok) begin
      drop_d = sat_inc8(drop_q);
      ovf_d  = 1'b1;
    end
    if (start) begin
      state_d = S_CAPTURE;
      ts_d    = '0;
      limit_d = cycle_limit;
      drop_d  = '0;
      ovf_d   = 1'b0;
    end else if (state_q == S_CAPTURE) begin
      ts_d = ts_q + TS_W'(1);
      if (limit_q != '0 && ts_q == limit_q - TS_W'(1)) begin
        state_d = S_DONE;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ts_q     <= '0;
      limit_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      limit_q  <= limit_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_entry_d;
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q];
  assign {bus.rd_ts, bus.rd_mask, bus.rd_addr, bus.rd_data} = head;
  assign bus.rd_valid = !empty;

  assign count     = count_q;
  assign capturing = (state_q == S_CAPTURE);
  assign done      = (state_q == S_DONE);
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule
